ps2_keyboard_rx: RTL and testbench



---
 rtl/ps2_pkg.sv | 21 ++
 rtl/ps2_code_fifo.sv | 53 +++++
 rtl/ps2_keyboard_rx.sv | 200 ++++++++++++++++++++
 tb/tb_ps2_keyboard_rx.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 keyboard receiver.
package ps2_pkg;

  // Frame receiver states
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } ps2_state_e;

  // Prefix bytes that modify the following scan code
  localparam logic [7:0] PS2_PREFIX_EXT = 8'hE0;
  localparam logic [7:0] PS2_PREFIX_BRK = 8'hF0;

  // Layout of a queued code: {expand, break, byte[7:0]}
  localparam int CODE_W   = 10;
  localparam int CODE_EXP = 9;
  localparam int CODE_BRK = 8;

endpackage

// File: rtl/ps2_code_fifo.sv
// Synchronous show-ahead FIFO for decoded scan codes.
// dout always presents the head entry; push while full is dropped unless a
// pop happens in the same cycle, and pop while empty is ignored.
module ps2_code_fifo #(
  parameter int WIDTH = 10,
  parameter int DEPTH = 8,
  parameter int AW    = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             empty,
  output logic             full
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr];

  // Storage, pointers and occupancy; mem is cleared so the head reads zero after reset
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (do_pop) rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/ps2_keyboard_rx.sv
// PS/2 keyboard receiver: synchronises the raw PS/2 lines, decodes 11-bit
// frames (start, 8 data LSB first, odd parity, stop), folds E0/F0 prefixes
// into the code and queues {expand, break, byte} in a show-ahead FIFO.
// A partial frame is abandoned after TIMEOUT_CYCLES clocks without a falling
// edge on ps2_clk.
//
// Optional build macro PS2_RX_TYPEMATIC_FILTER_EN: drop a make code that
// repeats the last queued make (keyboard auto-repeat) until a break, frame
// error or reset intervenes.
//
// Read handshake: code_valid=1 means code_out holds the oldest entry; driving
// rd_en=1 in that cycle pops it at the clock edge. rd_en with code_valid=0 is
// ignored.
module ps2_keyboard_rx
  import ps2_pkg::*;
#(
  parameter int SYNC_STAGES    = 3,
  parameter int TIMEOUT_CYCLES = 50000,
  parameter int FIFO_DEPTH     = 8,
  parameter int FIFO_AW        = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  input  logic       rd_en,
  output logic [9:0] code_out,
  output logic       code_valid,
  output logic       fifo_full,
  output logic       overflow,
  output logic       frame_err
);

  localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;

  logic [SYNC_STAGES-1:0] clk_sync;
  logic [SYNC_STAGES-1:0] data_sync;
  logic                   clk_prev;
  logic                   fe;
  logic                   din;

  ps2_state_e             state;
  logic [2:0]             bit_cnt;
  logic [7:0]             shift_reg;
  logic                   parity_bit;
  logic                   expand;
  logic                   brk;
  logic [TW-1:0]          tmo_cnt;

  logic                   frame_good;
  logic                   is_prefix;
  logic                   repeat_make;
  logic                   timeout_hit;
  logic                   push;
  logic [CODE_W-1:0]      code;
  logic                   fifo_empty;

  // Synchronise both PS/2 lines; reset to the idle-high bus level so no false edge appears
  always_ff @(posedge clk) begin
    if (rst) begin
      clk_sync  <= '1;
      data_sync <= '1;
      clk_prev  <= 1'b1;
    end else begin
      clk_sync  <= {clk_sync[SYNC_STAGES-2:0], ps2_clk};
      data_sync <= {data_sync[SYNC_STAGES-2:0], ps2_data};
      clk_prev  <= clk_sync[SYNC_STAGES-1];
    end
  end

  assign fe  = clk_prev && !clk_sync[SYNC_STAGES-1];
  assign din = data_sync[SYNC_STAGES-1];

  assign frame_good  = (state == STOP) && fe && din && (^{shift_reg, parity_bit});
  assign is_prefix   = (shift_reg == PS2_PREFIX_EXT) || (shift_reg == PS2_PREFIX_BRK);
  assign timeout_hit = (state != IDLE) && !fe && (tmo_cnt == TW'(TIMEOUT_CYCLES - 1));

  always_comb begin
    code            = '0;
    code[CODE_EXP]  = expand;
    code[CODE_BRK]  = brk;
    code[7:0]       = shift_reg;
  end

`ifdef PS2_RX_TYPEMATIC_FILTER_EN
  logic       last_valid;
  logic [8:0] last_make;

  assign repeat_make = !brk && last_valid && (last_make == {expand, shift_reg});

  // Remember the last make queued; any break or frame error forgets it
  always_ff @(posedge clk) begin
    if (rst) begin
      last_valid <= 1'b0;
      last_make  <= '0;
    end else if (timeout_hit || ((state == STOP) && fe && !frame_good)) begin
      last_valid <= 1'b0;
    end else if (frame_good && !is_prefix) begin
      if (brk) begin
        last_valid <= 1'b0;
      end else begin
        last_valid <= 1'b1;
        last_make  <= {expand, shift_reg};
      end
    end
  end
`else
  assign repeat_make = 1'b0;
`endif

  // Push lands on the stop-bit edge so code_valid rises on the following cycle
  assign push = frame_good && !is_prefix && !repeat_make;

  // Frame FSM with timeout, prefix tracking and error pulse
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      bit_cnt    <= '0;
      shift_reg  <= '0;
      parity_bit <= 1'b0;
      expand     <= 1'b0;
      brk        <= 1'b0;
      tmo_cnt    <= '0;
      frame_err  <= 1'b0;
    end else begin
      frame_err <= 1'b0;
      if ((state == IDLE) || fe) tmo_cnt <= '0;
      else                       tmo_cnt <= tmo_cnt + TW'(1);

      if (timeout_hit) begin
        state     <= IDLE;
        frame_err <= 1'b1;
        expand    <= 1'b0;
        brk       <= 1'b0;
        tmo_cnt   <= '0;
      end else if (fe) begin
        case (state)
          IDLE: begin
            // A high start bit is treated as noise and ignored
            if (!din) begin
              state   <= DATA;
              bit_cnt <= '0;
            end
          end
          DATA: begin
            shift_reg <= {din, shift_reg[7:1]};
            bit_cnt   <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) state <= PARITY;
          end
          PARITY: begin
            parity_bit <= din;
            state      <= STOP;
          end
          STOP: begin
            state <= IDLE;
            if (frame_good) begin
              if (shift_reg == PS2_PREFIX_EXT) begin
                expand <= 1'b1;
              end else if (shift_reg == PS2_PREFIX_BRK) begin
                brk <= 1'b1;
              end else begin
                expand <= 1'b0;
                brk    <= 1'b0;
              end
            end else begin
              frame_err <= 1'b1;
              expand    <= 1'b0;
              brk       <= 1'b0;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  // Sticky flag: a code was lost because the FIFO was full and not being read
  always_ff @(posedge clk) begin
    if (rst)                            overflow <= 1'b0;
    else if (push && fifo_full && !rd_en) overflow <= 1'b1;
  end

  ps2_code_fifo #(
    .WIDTH (CODE_W),
    .DEPTH (FIFO_DEPTH),
    .AW    (FIFO_AW)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .din   (code),
    .pop   (rd_en),
    .dout  (code_out),
    .empty (fifo_empty),
    .full  (fifo_full)
  );

  assign code_valid = !fifo_empty;

endmodule

// File: tb/tb_ps2_keyboard_rx.sv
// Bench for ps2_keyboard_rx: byte-level model of the keyboard protocol with a
// code queue, checked against the DUT every cycle outside of frame transfers.
module tb_ps2_keyboard_rx;

  localparam int SYNC  = 3;
  localparam int TMO   = 200;
  localparam int DEPTH = 8;
  localparam int AW    = 3;
  localparam int HALF  = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic       rd_en = 1'b0;
  logic [9:0] code_out;
  logic       code_valid;
  logic       fifo_full;
  logic       overflow;
  logic       frame_err;

  int checks = 0;
  int errors = 0;

  // Model state
  logic [9:0] exp_q[$];
  logic       exp_ovf = 1'b0;
  logic       m_ext = 1'b0;
  logic       m_brk = 1'b0;
  logic       m_last_valid = 1'b0;
  logic [8:0] m_last = '0;
  int         exp_err = 0;
  int         err_seen = 0;
  logic       err_prev = 1'b0;
  bit         chk_en = 1'b0;
  bit         lat_measure = 1'b0;

  // Clock
  always #5 clk = ~clk;

  ps2_keyboard_rx #(
    .SYNC_STAGES    (SYNC),
    .TIMEOUT_CYCLES (TMO),
    .FIFO_DEPTH     (DEPTH),
    .FIFO_AW        (AW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .ps2_clk    (ps2_clk),
    .ps2_data   (ps2_data),
    .rd_en      (rd_en),
    .code_out   (code_out),
    .code_valid (code_valid),
    .fifo_full  (fifo_full),
    .overflow   (overflow),
    .frame_err  (frame_err)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // ---------------- model ----------------
  task automatic model_reset();
    exp_q.delete();
    exp_ovf      = 1'b0;
    m_ext        = 1'b0;
    m_brk        = 1'b0;
    m_last_valid = 1'b0;
  endtask

  task automatic model_err();
    m_ext        = 1'b0;
    m_brk        = 1'b0;
    m_last_valid = 1'b0;
    exp_err++;
  endtask

  task automatic model_byte(input logic [7:0] b);
    bit skip;
    skip = 1'b0;
    if (b == 8'hE0) m_ext = 1'b1;
    else if (b == 8'hF0) m_brk = 1'b1;
    else begin
`ifdef PS2_RX_TYPEMATIC_FILTER_EN
      if (m_brk) m_last_valid = 1'b0;
      else if (m_last_valid && m_last == {m_ext, b}) skip = 1'b1;
      else begin
        m_last_valid = 1'b1;
        m_last       = {m_ext, b};
      end
`endif
      if (!skip) begin
        if (exp_q.size() < DEPTH) exp_q.push_back({m_ext, m_brk, b});
        else exp_ovf = 1'b1;
      end
      m_ext = 1'b0;
      m_brk = 1'b0;
    end
  endtask

  // ---------------- drivers ----------------
  task automatic ps2_bit(input logic b);
    ps2_data = b;
    cyc(HALF);
    ps2_clk = 1'b0;
    cyc(HALF);
    ps2_clk = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] b, input bit bad_par = 1'b0, input bit stop = 1'b1);
    logic par;
    int   lat;
    par    = (~^b) ^ bad_par;
    chk_en = 1'b0;
    ps2_bit(1'b0);
    for (int i = 0; i < 8; i++) ps2_bit(b[i]);
    ps2_bit(par);
    ps2_data = stop;
    cyc(HALF);
    ps2_clk = 1'b0;
    if (lat_measure) begin
      lat = 0;
      while (!code_valid && lat < 20) begin
        @(posedge clk);
        lat++;
        #1;
      end
      check("push_latency", lat, SYNC + 1);
      lat_measure = 1'b0;
    end
    cyc(HALF);
    ps2_clk = 1'b1;
    cyc(10);
    if (stop && (^{b, par})) model_byte(b);
    else model_err();
    check("frame_err_count", err_seen, exp_err);
    chk_en = 1'b1;
  endtask

  task automatic send_partial(input int nbits);
    chk_en = 1'b0;
    ps2_bit(1'b0);
    for (int i = 0; i < nbits; i++) ps2_bit(i[0]);
  endtask

  task automatic pop();
    rd_en = 1'b1;
    @(posedge clk);
    #1;
    rd_en = 1'b0;
    if (exp_q.size() > 0) void'(exp_q.pop_front());
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_code_out"}, code_out, 10'h000);
    check({tag, "_code_valid"}, code_valid, 1'b0);
    check({tag, "_fifo_full"}, fifo_full, 1'b0);
    check({tag, "_overflow"}, overflow, 1'b0);
    check({tag, "_frame_err"}, frame_err, 1'b0);
  endtask

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    if (rst) begin
      err_prev = 1'b0;
    end else begin
      if (frame_err) begin
        err_seen++;
        check("err_pulse_single", err_prev, 1'b0);
      end
      err_prev = frame_err;
      if (chk_en) begin
        check("code_valid", code_valid, exp_q.size() != 0);
        if (exp_q.size() != 0) check("code_out", code_out, exp_q[0]);
        check("fifo_full", fifo_full, exp_q.size() == DEPTH);
        check("overflow", overflow, exp_ovf);
      end
    end
  end

  // Watchdog
  initial begin
    #500us;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  // ---------------- directed stimulus ----------------
  initial begin
    rst = 1'b1;
    cyc(3);
    check_reset_outputs("reset");
    rst = 1'b0;
    model_reset();
    cyc(2);
    chk_en = 1'b1;

    // Plain make code with push latency
    lat_measure = 1'b1;
    send_frame(8'h29);
    check("make_29", code_out, 10'h029);
    check("make_29_valid", code_valid, 1'b1);
    pop();
    check("make_29_popped", code_valid, 1'b0);

    // Break prefix
    send_frame(8'hF0);
    check("f0_no_push", code_valid, 1'b0);
    send_frame(8'h29);
    check("brk_29", code_out, 10'h129);
    pop();
    check("brk_29_single", code_valid, 1'b0);

    // Extended break
    send_frame(8'hE0);
    send_frame(8'hF0);
    send_frame(8'h75);
    check("ext_brk_75", code_out, 10'h375);
    pop();

    // Extended make
    send_frame(8'hE0);
    send_frame(8'h75);
    check("ext_75", code_out, 10'h275);
    pop();

    // Parity error clears a pending E0 prefix
    send_frame(8'hE0);
    send_frame(8'h1C, 1'b1);
    check("par_err_count", err_seen, 1);
    check("par_err_no_push", code_valid, 1'b0);
    send_frame(8'hF0);
    send_frame(8'h1C);
    check("after_err_11c", code_out, 10'h11C);
    pop();

    // Fill past capacity with repeated makes
    for (int i = 0; i < 9; i++) begin
      send_frame(8'h1C);
`ifdef PS2_RX_TYPEMATIC_FILTER_EN
      if (i == 7) check("filt_not_full", fifo_full, 1'b0);
      if (i == 8) check("filt_no_ovf", overflow, 1'b0);
`else
      if (i == 7) check("full_after_8", fifo_full, 1'b1);
      if (i == 7) check("no_ovf_at_8", overflow, 1'b0);
      if (i == 8) check("ovf_after_9", overflow, 1'b1);
`endif
    end
`ifdef PS2_RX_TYPEMATIC_FILTER_EN
    check("filt_head", code_out, 10'h01C);
    pop();
    check("filt_one_entry", code_valid, 1'b0);
`else
    for (int i = 0; i < 8; i++) begin
      check("drain_01c", code_out, 10'h01C);
      pop();
    end
    check("drained", code_valid, 1'b0);
    check("ovf_sticky", overflow, 1'b1);
`endif

    // Timeout on a partial frame with a pending E0
    send_frame(8'hE0);
    send_partial(4);
    cyc(TMO + 50);
    model_err();
    check("timeout_err_count", err_seen, 2);
    chk_en = 1'b1;
    send_frame(8'h1C);
    check("after_timeout_01c", code_out, 10'h01C);
    pop();

    // Reset mid-frame with codes queued
    send_frame(8'h29);
    send_frame(8'h1C);
    send_frame(8'h75);
    check("queued_head", code_out, 10'h029);
    send_partial(3);
    rst = 1'b1;
    cyc(2);
    check_reset_outputs("mid_rst");
    ps2_clk  = 1'b1;
    ps2_data = 1'b1;
    rst = 1'b0;
    model_reset();
    cyc(2);
    chk_en = 1'b1;
    send_frame(8'h29);
    check("post_rst_29", code_out, 10'h029);
    pop();
    check("post_rst_empty", code_valid, 1'b0);
    cyc(5);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
